// File: rtl/fetch_queue_pkg.sv
// Shared fetch front-end types and constants.
package fetch_queue_pkg;

  localparam int unsigned FQ_PC_W  = 9;
  localparam int unsigned FQ_INS_W = 32;
  localparam int unsigned FQ_DEPTH = 4;
  localparam int unsigned PC_STEP  = 4;

  // One queued fetch result: the address it came from and the returned word.
  typedef struct packed {
    logic [FQ_PC_W-1:0]  pc;
    logic [FQ_INS_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue storage: circular buffer with head/tail/count and a
// flush that empties it in one cycle. Flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned W     = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic [W-1:0]                   push_data,
  input  logic                           pop,
  output logic [W-1:0]                   head_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head, head_n, tail, tail_n;
  logic [CNT_W-1:0] count_n;
  logic             pop_ok;

  assign pop_ok    = pop && (count != '0);
  assign head_data = mem[head];

  // Next pointer/count values.
  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    if (flush) begin
      head_n  = '0;
      tail_n  = '0;
      count_n = '0;
    end else begin
      if (push)   tail_n = tail + PTR_W'(1);
      if (pop_ok) head_n = head + PTR_W'(1);
      if (push && !pop_ok)      count_n = count + CNT_W'(1);
      else if (!push && pop_ok) count_n = count - CNT_W'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
    end
  end

  // Entry storage; data itself needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) mem[tail] <= push_data;
  end

  // The issue throttle upstream must never let a push land on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && !pop_ok && count == CNT_W'(DEPTH)))
    else $error("fetch_fifo: push into full queue");

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one-cycle-latency
// imem reads, buffers results and presents {pc, instr} to IF/ID in order.
// Optional macro FETCH_BYPASS_EN forwards returning data straight to the
// outputs when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     PC_W     = FQ_PC_W,
  parameter int unsigned     INS_W    = FQ_INS_W,
  parameter int unsigned     DEPTH    = FQ_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             stall,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ENT_W = PC_W + INS_W;

  logic [PC_W-1:0]  fpc, fpc_n;
  logic [PC_W-1:0]  inflight_pc, inflight_pc_n;
  logic             inflight, inflight_n;
  logic [CNT_W-1:0] q_count;
  logic [ENT_W-1:0] head_data;
  logic             q_nonempty;
  logic             issue_c;
  logic             bypass_c;
  logic             push_c;
  logic             pop_c;

  assign q_nonempty = (q_count != '0);

  // Issue only while queued plus in-flight entries leave a free slot.
  assign issue_c = !reset && !redirect &&
                   ((OCC_W'(q_count) + OCC_W'(inflight)) < OCC_W'(DEPTH));

`ifdef FETCH_BYPASS_EN
  assign bypass_c = !q_nonempty && inflight && !redirect;
`else
  assign bypass_c = 1'b0;
`endif

  // A bypassed word consumed this cycle is not written into the queue.
  assign push_c = inflight && !redirect && !(bypass_c && !stall);
  assign pop_c  = q_nonempty && !stall && !redirect;

  assign imem_req  = issue_c;
  assign imem_addr = fpc;

  fetch_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push_c),
    .push_data ({inflight_pc, imem_rdata}),
    .pop       (pop_c),
    .head_data (head_data),
    .count     (q_count)
  );

  // IF/ID view: queue head, else bypassed return data, else zeros.
  always_comb begin
    if_valid = q_nonempty || bypass_c;
    if_pc    = '0;
    if_instr = '0;
    if (q_nonempty)    {if_pc, if_instr} = head_data;
    else if (bypass_c) {if_pc, if_instr} = {inflight_pc, imem_rdata};
  end

  // Next fetch PC and in-flight tracking; redirect restarts word-aligned.
  always_comb begin
    fpc_n         = fpc;
    inflight_n    = 1'b0;
    inflight_pc_n = inflight_pc;
    if (redirect) begin
      fpc_n = {redirect_pc[PC_W-1:2], 2'b00};
    end else if (issue_c) begin
      fpc_n         = fpc + PC_W'(PC_STEP);
      inflight_n    = 1'b1;
      inflight_pc_n = fpc;
    end
  end

  // Fetch PC and in-flight registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      fpc         <= fpc_n;
      inflight    <= inflight_n;
      inflight_pc <= inflight_pc_n;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, no bypass) with a
// one-cycle-latency instruction memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;

  int n_total = 0;
  int n_pass  = 0;

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [8:0] pc);
    return {16'hC0DE, 7'd0, pc};
  endfunction

  // Synchronous memory: data for the address seen at an edge appears after it.
  always @(posedge clk) imem_rdata <= instr_of(imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_head(input string tag, input logic [8:0] pc);
    check({tag, " valid"}, 64'(if_valid), 64'd1);
    check({tag, " pc"},    64'(if_pc),    64'(pc));
    check({tag, " instr"}, 64'(if_instr), 64'(instr_of(pc)));
  endtask

  task automatic expect_empty(input string tag);
    check({tag, " valid"}, 64'(if_valid), 64'd0);
    check({tag, " pc"},    64'(if_pc),    64'd0);
    check({tag, " instr"}, 64'(if_instr), 64'd0);
  endtask

  // Advance one cycle, apply inputs just after the edge, let them settle.
  task automatic drive(input logic rst, input logic s, input logic r, input logic [8:0] rp);
    @(posedge clk);
    #1;
    reset       = rst;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    drive(1, 0, 0, 9'h000);
    drive(1, 0, 0, 9'h000);
    expect_empty("reset");
    check("reset req",  64'(imem_req),  64'd0);
    check("reset addr", 64'(imem_addr), 64'd0);

    // Stream from reset release (cycle 0).
    drive(0, 0, 0, 9'h000);
    check("c0 req",  64'(imem_req),  64'd1);
    check("c0 addr", 64'(imem_addr), 64'h000);
    expect_empty("c0");
    drive(0, 0, 0, 9'h000);
    check("c1 addr", 64'(imem_addr), 64'h004);
    check("c1 valid", 64'(if_valid), 64'd0);
    for (int c = 2; c <= 4; c++) begin
      drive(0, 0, 0, 9'h000);
      expect_head("stream", 9'(4 * (c - 2)));
      check("stream addr", 64'(imem_addr), 64'(4 * c));
    end

    // Stall cycles 5..14: queue fills, requests stop, head holds at 0x00C.
    for (int c = 5; c <= 14; c++) begin
      drive(0, 1, 0, 9'h000);
      if (c == 7)  check("stall c7 req", 64'(imem_req), 64'd0);
      if (c == 14) begin
        check("stall full req",  64'(imem_req),  64'd0);
        check("stall full addr", 64'(imem_addr), 64'h01C);
        expect_head("stall hold", 9'h00C);
      end
    end

    // Release: order continues without gap or duplicate.
    for (int c = 15; c <= 22; c++) begin
      drive(0, 0, 0, 9'h000);
      expect_head("release", 9'(12 + 4 * (c - 15)));
      if (c == 15) check("release first-pop req", 64'(imem_req), 64'd0);
      if (c == 16) check("release resume req",    64'(imem_req), 64'd1);
    end

    // Redirect from streaming to 0x100.
    drive(0, 0, 1, 9'h100);
    check("redir req", 64'(imem_req), 64'd0);
    drive(0, 0, 0, 9'h000);
    expect_empty("redir+1");
    check("redir+1 addr", 64'(imem_addr), 64'h100);
    check("redir+1 req",  64'(imem_req),  64'd1);
    drive(0, 0, 0, 9'h000);
    check("redir+2 valid", 64'(if_valid), 64'd0);
    drive(0, 1, 0, 9'h000);
    expect_head("redir+3", 9'h100);
    drive(0, 1, 0, 9'h000);
    // Three entries queued, stall still high: redirect must win.
    drive(0, 1, 1, 9'h040);
    expect_head("pre-flush", 9'h100);
    check("flush req", 64'(imem_req), 64'd0);
    drive(0, 0, 0, 9'h000);
    expect_empty("flush+1");
    check("flush+1 addr", 64'(imem_addr), 64'h040);
    check("flush+1 req",  64'(imem_req),  64'd1);
    drive(0, 0, 0, 9'h000);
    check("flush+2 valid", 64'(if_valid), 64'd0);
    drive(0, 0, 0, 9'h000);
    expect_head("flush+3", 9'h040);
    drive(0, 0, 0, 9'h000);
    expect_head("flush+4", 9'h044);

    // Unaligned redirect near the top of the address space wraps to 0.
    drive(0, 0, 1, 9'h1FE);
    drive(0, 0, 0, 9'h000);
    check("wrap addr0", 64'(imem_addr), 64'h1FC);
    drive(0, 0, 0, 9'h000);
    check("wrap addr1", 64'(imem_addr), 64'h000);
    drive(0, 0, 0, 9'h000);
    expect_head("wrap head0", 9'h1FC);
    drive(0, 0, 0, 9'h000);
    expect_head("wrap head1", 9'h000);

    // Fill the queue, then reset with it full.
    for (int c = 0; c < 4; c++) drive(0, 1, 0, 9'h000);
    check("fill req", 64'(imem_req), 64'd0);
    expect_head("fill head", 9'h004);
    drive(1, 1, 0, 9'h000);
    check("rst-in req", 64'(imem_req), 64'd0);
    drive(1, 1, 0, 9'h000);
    expect_empty("rst+1");
    check("rst+1 addr", 64'(imem_addr), 64'h000);
    drive(0, 0, 0, 9'h000);
    check("rst rel req",  64'(imem_req),  64'd1);
    check("rst rel addr", 64'(imem_addr), 64'h000);
    drive(0, 0, 0, 9'h000);
    check("rst rel+1 valid", 64'(if_valid), 64'd0);
    drive(0, 0, 0, 9'h000);
    expect_head("rst rel+2", 9'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
